// File: rtl/multi_debounce_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package multi_debounce_pkg;

    // Per-channel registered output state.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
    } key_evt_t;

    // Repeat counter width; a 1-bit floor keeps a disabled repeat from producing a zero-width vector.
    function automatic int unsigned cnt_width(input int unsigned rep_dly);
        return (rep_dly == 0) ? 1 : $clog2(rep_dly + 1);
    endfunction

endpackage

// File: rtl/multi_debounce_if.sv
// Key bundle between the board pins (master) and the debouncer (slave).
interface multi_debounce_if #(
    parameter int unsigned N_CH = 2
) ();
    logic [N_CH-1:0] X;
    logic [N_CH-1:0] X_level;
    logic [N_CH-1:0] X_press;
    logic [N_CH-1:0] X_rel;

    modport master (
        output X,
        input  X_level,
        input  X_press,
        input  X_rel
    );

    modport slave (
        input  X,
        output X_level,
        output X_press,
        output X_rel
    );
endinterface

// File: rtl/multi_debounce_heartbeat.sv
// Free-running divider: one registered tick every 2^HB_WIDTH clocks, counter restarts at reset.
module multi_debounce_heartbeat #(
    parameter int unsigned HB_WIDTH = 21
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    logic [HB_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + HB_WIDTH'(1);
            o_tick <= (r_cnt == '1);
        end
    end
endmodule

// File: rtl/multi_debounce.sv
// N-channel key debouncer: synchronise, sample on a shared tick, filter with hysteresis,
// and emit a clean level plus press/release pulses with optional auto-repeat.
module multi_debounce
    import multi_debounce_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned HB_WIDTH  = 21,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned EXCLUSIVE = 1,
    parameter int unsigned REP_DLY   = 0,
    parameter int unsigned REP_RATE  = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    multi_debounce_if.slave  io_keys
);
    localparam logic [DEPTH-1:0] SR_ONES = '1;

    if (DEPTH < 2) begin : g_chk_depth
        $error("multi_debounce: DEPTH must be >= 2");
    end
    if (REP_DLY > 0 && REP_RATE < 1) begin : g_chk_rate
        $error("multi_debounce: REP_RATE must be >= 1");
    end
    if (REP_DLY > 0 && REP_RATE > REP_DLY) begin : g_chk_rate_dly
        $error("multi_debounce: REP_RATE must not exceed REP_DLY");
    end

    logic            w_tick;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] w_rel;

    multi_debounce_heartbeat #(
        .HB_WIDTH (HB_WIDTH)
    ) u_heartbeat (
        .i_clk  (sysclk),
        .i_rst  (reset),
        .o_tick (w_tick)
    );

    // Two-flop synchroniser on the raw pins, running every clock.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= io_keys.X;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [N_CH-1:0]  w_others;
        logic             w_sample;
        logic             w_level_nxt;
        logic             w_rep_hit;
        logic [DEPTH-1:0] r_sr;
        key_evt_t         r_evt;

        // Exclusive keypads treat any chord as "nothing pressed".
        assign w_others = r_sync2 & ~(N_CH'(1) << i);
        assign w_sample = r_sync2[i] & ((EXCLUSIVE == 0) | ~|w_others);

        always_comb begin
            w_level_nxt = r_evt.level;
            if (r_sr == SR_ONES) begin
                w_level_nxt = 1'b1;
            end else if (r_sr == '0) begin
                w_level_nxt = 1'b0;
            end
        end

        always_ff @(posedge sysclk) begin
            if (reset) begin
                r_sr  <= '0;
                r_evt <= '0;
            end else begin
                if (w_tick) begin
                    r_sr <= {r_sr[DEPTH-2:0], w_sample};
                end
                r_evt.level <= w_level_nxt;
                r_evt.press <= (w_level_nxt & ~r_evt.level) | w_rep_hit;
                r_evt.rel   <= ~w_level_nxt & r_evt.level;
            end
        end

        if (REP_DLY > 0) begin : g_rep
            localparam int unsigned CW = cnt_width(REP_DLY);
            logic [CW-1:0] r_cnt;
            logic          r_hit;

            // Held-key tick counter; hit is raised on the tick edge and becomes a press one clock later.
            always_ff @(posedge sysclk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_hit <= 1'b0;
                end else begin
                    r_hit <= 1'b0;
                    if (!r_evt.level) begin
                        r_cnt <= '0;
                    end else if (w_tick) begin
                        if (r_cnt == CW'(REP_DLY - 1)) begin
                            r_cnt <= CW'(REP_DLY - REP_RATE);
                            r_hit <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
            end

            assign w_rep_hit = r_hit;
        end else begin : g_no_rep
            assign w_rep_hit = 1'b0;
        end

        assign w_level[i] = r_evt.level;
        assign w_press[i] = r_evt.press;
        assign w_rel[i]   = r_evt.rel;
    end

    assign io_keys.X_level = w_level;
    assign io_keys.X_press = w_press;
    assign io_keys.X_rel   = w_rel;
endmodule
